// File: rtl/cmp_seq_if.sv
// Handshake bundle for cmp_seq: request side (operands + mode) and result side.
// master drives requests and out_ready; slave is the comparator.
interface cmp_seq_if #(
    parameter int unsigned WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic             out;
    logic             eq;
    logic             lt;

    modport master (
        output in_valid, d1, d2, mode, out_ready,
        input  in_ready, out_valid, out, eq, lt
    );

    modport slave (
        input  in_valid, d1, d2, mode, out_ready,
        output in_ready, out_valid, out, eq, lt
    );
endinterface

// File: rtl/cmp_seq.sv
// Sequential unsigned comparator: compares WIDTH-bit operands CHUNK bits per cycle,
// most significant chunk first, and reports eq/lt plus a mode-selected result.
// Build option: define EARLY_EXIT_EN to finish right after the first mismatching
// chunk; otherwise every chunk is always scanned (constant-time compare).
module cmp_seq #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned CHUNK = 32
) (
    input logic      clk,
    input logic      rst,
    cmp_seq_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLast = KW'(NCHUNK - 1);

    localparam logic [1:0] ModeEq  = 2'b00;
    localparam logic [1:0] ModeNe  = 2'b01;
    localparam logic [1:0] ModeLtu = 2'b10;
    localparam logic [1:0] ModeGtu = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       mode_q;
    logic [KW-1:0]    k_q;
    // First-mismatch record: found_q set once, lt_acc_q holds its ordering.
    logic             found_q;
    logic             lt_acc_q;
    logic             out_valid_q;
    logic             out_q;
    logic             eq_q;
    logic             lt_q;

    logic [CHUNK-1:0] a_arr [NCHUNK];
    logic [CHUNK-1:0] b_arr [NCHUNK];
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_ne;
    logic             chunk_lt;
    logic             found_n;
    logic             lt_n;
    logic             eq_n;
    logic             out_n;
    logic             run_done;

    // Chunk view of the held operands; index 0 is the least significant chunk.
    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        assign a_arr[g] = a_q[g*CHUNK +: CHUNK];
        assign b_arr[g] = b_q[g*CHUNK +: CHUNK];
    end

    // Compare the current chunk and fold it into the running first-mismatch result.
    always_comb begin
        a_chunk  = a_arr[KLast - k_q];
        b_chunk  = b_arr[KLast - k_q];
        chunk_ne = (a_chunk != b_chunk);
        chunk_lt = (a_chunk < b_chunk);
        // An earlier mismatch always wins over anything seen in later chunks.
        found_n  = found_q | chunk_ne;
        lt_n     = found_q ? lt_acc_q : chunk_lt;
        eq_n     = ~found_n;
        out_n    = 1'b0;
        unique case (mode_q)
            ModeEq:  out_n = eq_n;
            ModeNe:  out_n = ~eq_n;
            ModeLtu: out_n = lt_n;
            ModeGtu: out_n = ~eq_n & ~lt_n;
            default: out_n = 1'b0;
        endcase
`ifdef EARLY_EXIT_EN
        run_done = (k_q == KLast) | chunk_ne;
`else
        run_done = (k_q == KLast);
`endif
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= ModeEq;
            k_q         <= '0;
            found_q     <= 1'b0;
            lt_acc_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.d1;
                        b_q      <= bus.d2;
                        mode_q   <= bus.mode;
                        k_q      <= '0;
                        found_q  <= 1'b0;
                        lt_acc_q <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (run_done) begin
                        eq_q        <= eq_n;
                        lt_q        <= lt_n;
                        out_q       <= out_n;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        k_q      <= k_q + 1'b1;
                        found_q  <= found_n;
                        lt_acc_q <= lt_n;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // in_ready is held low during reset, then follows the IDLE state directly.
    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.eq        = eq_q;
    assign bus.lt        = lt_q;

    // A pending result must stay put until the consumer takes it.
    property p_hold_result;
        @(posedge clk) disable iff (rst)
            bus.out_valid && !bus.out_ready |=>
                bus.out_valid && $stable({bus.out, bus.eq, bus.lt});
    endproperty
    a_hold_result: assert property (p_hold_result);

    // Never ready for a new request while a result is outstanding.
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.out_valid));

    // Equal and less-than cannot both be reported.
    a_eq_lt_excl: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid |-> !(bus.eq && bus.lt));
endmodule
